// File: rtl/harmonic_mix_accumulator_pkg.sv
// Shared definitions for the harmonic mix accumulator.
// Holds the default widths, the FSM state encoding and the saturation
// limits of the accumulator and of the output mix sample.
package harmonic_mix_accumulator_pkg;

   localparam int DIV_BIT_DEF    = 11;
   localparam int SAMPLE_BIT_DEF = 16;
   localparam int ACC_BIT_DEF    = 24;
   localparam int OUT_SHIFT_DEF  = 4;

   typedef enum logic [1:0] {
      sm_idle   = 2'd0,
      sm_mult   = 2'd1,
      sm_accum  = 2'd2,
      sm_output = 2'd3
   } state_t;

   localparam logic signed [ACC_BIT_DEF-1:0] ACC_MAX =
      {1'b0, {(ACC_BIT_DEF-1){1'b1}}};
   localparam logic signed [ACC_BIT_DEF-1:0] ACC_MIN =
      {1'b1, {(ACC_BIT_DEF-1){1'b0}}};
   localparam logic signed [SAMPLE_BIT_DEF-1:0] MIX_MAX =
      {1'b0, {(SAMPLE_BIT_DEF-1){1'b1}}};
   localparam logic signed [SAMPLE_BIT_DEF-1:0] MIX_MIN =
      {1'b1, {(SAMPLE_BIT_DEF-1){1'b0}}};

endpackage

// File: rtl/harmonic_mix_accumulator_if.sv
// Harmonic/mix handshake bundle between the upstream sine and multiple
// stages and the mix accumulator.
//   slave  : the accumulator (takes i_* signals, drives o_* signals)
//   master : upstream source / consumer side
interface harmonic_mix_accumulator_if
   import harmonic_mix_accumulator_pkg::*;
#(
   parameter int DIV_BIT    = DIV_BIT_DEF,
   parameter int SAMPLE_BIT = SAMPLE_BIT_DEF
);
   logic                         i_Frame_Start;
   logic                         i_Sample_Valid;
   logic signed [SAMPLE_BIT-1:0] i_Sample;
   logic                         i_Last;
   logic        [DIV_BIT-1:0]    i_Mult;
   logic                         i_Mult_Ready;
   logic                         o_Ready;
   logic                         o_Scale_Start;
   logic signed [SAMPLE_BIT-1:0] o_Mix_Out;
   logic                         o_Mix_Valid;
   logic                         o_Overflow;

   modport master (
      output i_Frame_Start, i_Sample_Valid, i_Sample, i_Last, i_Mult, i_Mult_Ready,
      input  o_Ready, o_Scale_Start, o_Mix_Out, o_Mix_Valid, o_Overflow
   );

   modport slave (
      input  i_Frame_Start, i_Sample_Valid, i_Sample, i_Last, i_Mult, i_Mult_Ready,
      output o_Ready, o_Scale_Start, o_Mix_Out, o_Mix_Valid, o_Overflow
   );
endinterface

// File: rtl/harmonic_mix_accumulator_sat_shift.sv
// Arithmetic right shift followed by signed saturation to a narrower width.
// Ports:
//   i_Value : signed input, IN_W bits
//   o_Value : (i_Value >>> SHIFT) clipped to the signed OUT_W range
//   o_Sat   : high when clipping occurred
module harmonic_mix_accumulator_sat_shift #(
   parameter int IN_W  = 25,
   parameter int OUT_W = 24,
   parameter int SHIFT = 0
) (
   input  logic signed [IN_W-1:0]  i_Value,
   output logic signed [OUT_W-1:0] o_Value,
   output logic                    o_Sat
);
   localparam logic signed [IN_W-1:0] MAX_IN =
      {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_IN =
      {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // Returns {clipped, value}.
   function automatic logic [OUT_W:0] sat_fn(input logic signed [IN_W-1:0] v);
      logic signed [IN_W-1:0] s;
      s = v >>> SHIFT;
      if (s > MAX_IN)
         sat_fn = {1'b1, MAX_IN[OUT_W-1:0]};
      else if (s < MIN_IN)
         sat_fn = {1'b1, MIN_IN[OUT_W-1:0]};
      else
         sat_fn = {1'b0, s[OUT_W-1:0]};
   endfunction

   logic [OUT_W:0] res;

   always_comb begin
      res     = sat_fn(i_Value);
      o_Sat   = res[OUT_W];
      o_Value = res[OUT_W-1:0];
   end
endmodule

// File: rtl/harmonic_mix_accumulator.sv
// Harmonic mix accumulator: multiplies each harmonic's sine sample by its
// scaling multiple (unsigned fraction of 2^DIV_BIT), accumulates into a
// per-frame sum and emits one saturated, normalised mix sample on the last
// harmonic of the frame.
// Ports:
//   i_Clock   : clock, rising edge
//   i_Reset_n : asynchronous active-low reset
//   bus       : slave side of the harmonic/mix handshake (see interface)
module harmonic_mix_accumulator
   import harmonic_mix_accumulator_pkg::*;
#(
   parameter int DIV_BIT    = DIV_BIT_DEF,
   parameter int SAMPLE_BIT = SAMPLE_BIT_DEF,
   parameter int ACC_BIT    = ACC_BIT_DEF,
   parameter int OUT_SHIFT  = OUT_SHIFT_DEF
) (
   input  logic                           i_Clock,
   input  logic                           i_Reset_n,
   harmonic_mix_accumulator_if.slave      bus
);
   localparam int PROD_W = SAMPLE_BIT + DIV_BIT + 1;

   state_t                       state;
   logic                         ready_r;
   logic                         mix_valid_r;
   logic                         overflow_r;
   logic signed [SAMPLE_BIT-1:0] mix_out_r;
   logic signed [ACC_BIT-1:0]    acc;

   logic signed [SAMPLE_BIT-1:0] sample_p0;
   logic        [DIV_BIT-1:0]    mult_p0;
   logic                         last_p0;
   logic signed [PROD_W-1:0]     product_p1;

   logic                         accept;
   logic signed [PROD_W-1:0]     sample_ext;
   logic signed [PROD_W-1:0]     mult_ext;
   logic signed [PROD_W-1:0]     product_c;
   logic signed [ACC_BIT:0]      term;
   logic signed [ACC_BIT:0]      acc_sum;
   logic signed [ACC_BIT-1:0]    acc_next;
   logic                         acc_sat;
   logic signed [SAMPLE_BIT-1:0] mix_next;
   logic                         mix_sat;

   // Combinational so the upstream stage sees the pulse in the accept cycle.
   assign accept = i_Reset_n & (state == sm_idle) & bus.i_Sample_Valid
                 & bus.i_Mult_Ready & ~bus.i_Frame_Start;

   // Multiple is an unsigned fraction: zero-extend before the signed multiply.
   assign sample_ext = PROD_W'(sample_p0);
   assign mult_ext   = PROD_W'({1'b0, mult_p0});
   assign product_c  = sample_ext * mult_ext;

   assign term    = (ACC_BIT+1)'(product_p1 >>> DIV_BIT);
   assign acc_sum = (ACC_BIT+1)'(acc) + term;

   harmonic_mix_accumulator_sat_shift #(
      .IN_W(ACC_BIT+1), .OUT_W(ACC_BIT), .SHIFT(0)
   ) u_acc_sat (
      .i_Value(acc_sum), .o_Value(acc_next), .o_Sat(acc_sat)
   );

   // Output narrowing is taken from the freshly saturated sum, so the mix
   // sample is registered in the same edge that completes the last add.
   harmonic_mix_accumulator_sat_shift #(
      .IN_W(ACC_BIT), .OUT_W(SAMPLE_BIT), .SHIFT(OUT_SHIFT)
   ) u_out_sat (
      .i_Value(acc_next), .o_Value(mix_next), .o_Sat(mix_sat)
   );

   // Stage p0: harmonic capture / stage p1: registered product
   always_ff @(posedge i_Clock) begin
      if (accept) begin
         sample_p0 <= bus.i_Sample;
         mult_p0   <= bus.i_Mult;
         last_p0   <= bus.i_Last;
      end
      if (state == sm_mult)
         product_p1 <= product_c;
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state       <= sm_idle;
         acc         <= '0;
         ready_r     <= 1'b1;
         mix_out_r   <= '0;
         mix_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         mix_valid_r <= 1'b0;
         if (bus.i_Frame_Start) begin
            // Abort anything in flight; no mix is produced for this frame.
            state      <= sm_idle;
            acc        <= '0;
            overflow_r <= 1'b0;
            ready_r    <= 1'b1;
         end else begin
            case (state)
               sm_idle: begin
                  if (accept) begin
                     state   <= sm_mult;
                     ready_r <= 1'b0;
                  end
               end
               sm_mult: begin
                  state <= sm_accum;
               end
               sm_accum: begin
                  acc <= acc_next;
                  if (acc_sat)
                     overflow_r <= 1'b1;
                  if (last_p0) begin
                     mix_out_r   <= mix_next;
                     mix_valid_r <= 1'b1;
                     if (mix_sat)
                        overflow_r <= 1'b1;
                     state <= sm_output;
                  end else begin
                     state   <= sm_idle;
                     ready_r <= 1'b1;
                  end
               end
               sm_output: begin
                  acc     <= '0;
                  state   <= sm_idle;
                  ready_r <= 1'b1;
               end
               default: begin
                  state   <= sm_idle;
                  ready_r <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.o_Ready       = ready_r;
   assign bus.o_Scale_Start = accept;
   assign bus.o_Mix_Out     = mix_out_r;
   assign bus.o_Mix_Valid   = mix_valid_r;
   assign bus.o_Overflow    = overflow_r;
endmodule

// File: tb/tb_harmonic_mix_accumulator.sv
// Bench for harmonic_mix_accumulator: table-driven frames, hand sequences
// for reset/abort/stall, and random traffic against a transaction model.
module tb_harmonic_mix_accumulator;
   import harmonic_mix_accumulator_pkg::*;

   localparam int DIV_BIT    = 11;
   localparam int SAMPLE_BIT = 16;
   localparam int ACC_BIT    = 24;
   localparam int OUT_SHIFT  = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   harmonic_mix_accumulator_if #(.DIV_BIT(DIV_BIT), .SAMPLE_BIT(SAMPLE_BIT)) bus ();

   harmonic_mix_accumulator #(
      .DIV_BIT(DIV_BIT), .SAMPLE_BIT(SAMPLE_BIT), .ACC_BIT(ACC_BIT), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .i_Clock(clk), .i_Reset_n(rst_n), .bus(bus)
   );

   int     n_cmp  = 0;
   int     n_fail = 0;
   longint cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct { longint due; longint mix; bit ovf; } pend_t;
   pend_t  pend[$];
   longint m_acc;
   bit     m_ovf;
   longint m_busy;

   function automatic longint clip(input longint v, input longint lo, input longint hi,
                                   inout bit flag);
      if (v > hi) begin flag = 1'b1; return hi; end
      if (v < lo) begin flag = 1'b1; return lo; end
      return v;
   endfunction

   task automatic monitor_step();
      bit     exp_ready, exp_acc, c;
      longint s, m, v;
      pend_t  p;
      if (!rst_n) begin
         m_acc = 0; m_ovf = 0; m_busy = 0;
         pend.delete();
         return;
      end
      if (pend.size() > 0 && pend[0].due < cyc) begin
         chk(1'b0, "mix_missing", 0, pend[0].mix);
         void'(pend.pop_front());
      end
      exp_ready = (cyc >= m_busy);
      chk(bus.o_Ready == exp_ready, "mon_ready", bus.o_Ready, exp_ready);
      exp_acc = exp_ready && bus.i_Sample_Valid && bus.i_Mult_Ready && !bus.i_Frame_Start;
      chk(bus.o_Scale_Start == exp_acc, "mon_scale_start", bus.o_Scale_Start, exp_acc);
      if (bus.o_Mix_Valid) begin
         if (pend.size() == 0) begin
            chk(1'b0, "mix_unexpected", 1, 0);
         end else begin
            p = pend.pop_front();
            chk(p.due == cyc, "mix_latency", cyc, p.due);
            chk(longint'(bus.o_Mix_Out) == p.mix, "mon_mix", longint'(bus.o_Mix_Out), p.mix);
            chk(bus.o_Overflow == p.ovf, "mon_ovf", bus.o_Overflow, p.ovf);
         end
      end
      if (bus.i_Frame_Start) begin
         m_acc = 0; m_ovf = 0; m_busy = cyc + 1;
         pend.delete();
      end else if (exp_acc) begin
         s = longint'(bus.i_Sample);
         m = longint'(bus.i_Mult);
         c = 1'b0;
         m_acc = clip(m_acc + ((s * m) >>> DIV_BIT), longint'(ACC_MIN), longint'(ACC_MAX), c);
         if (bus.i_Last) begin
            v = clip(m_acc >>> OUT_SHIFT, longint'(MIX_MIN), longint'(MIX_MAX), c);
            if (c) m_ovf = 1'b1;
            p.due = cyc + 3; p.mix = v; p.ovf = m_ovf;
            pend.push_back(p);
            m_acc  = 0;
            m_busy = cyc + 4;
         end else begin
            if (c) m_ovf = 1'b1;
            m_busy = cyc + 3;
         end
      end
   endtask

   // ---------------- drive helpers (called at posedge + 1) ----------------
   task automatic pulse_fs();
      bus.i_Frame_Start = 1'b1;
      @(posedge clk); #1;
      bus.i_Frame_Start = 1'b0;
   endtask

   task automatic send(input int s, input int m, input bit last, output bit ok);
      bus.i_Sample       = SAMPLE_BIT'(s);
      bus.i_Mult         = DIV_BIT'(m);
      bus.i_Last         = last;
      bus.i_Sample_Valid = 1'b1;
      bus.i_Mult_Ready   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.o_Scale_Start) ok = 1'b1;
      end
      @(posedge clk); #1;
      bus.i_Sample_Valid = 1'b0;
      bus.i_Last         = 1'b0;
   endtask

   task automatic wait_mix(output longint v, output bit ovf, output bit got);
      v = 0; ovf = 1'b0; got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (bus.o_Mix_Valid) begin
            got = 1'b1;
            v   = longint'(bus.o_Mix_Out);
            ovf = bus.o_Overflow;
         end
      end
      @(posedge clk); #1;
   endtask

   typedef struct { int s; int m; int n; int exp_mix; bit exp_ovf; } vec_t;
   vec_t tbl[7];

   initial begin
      longint v;
      bit     ovf, got, ok;
      int     acc_cnt;

      tbl[0] = '{ 16384, 1024,   1,    512, 1'b0};
      tbl[1] = '{-16384, 1024,   1,   -512, 1'b0};
      tbl[2] = '{ 12345,    0,   1,      0, 1'b0};
      tbl[3] = '{ 32767, 2047,   1,   2046, 1'b0};
      tbl[4] = '{    -1, 2047,   1,     -1, 1'b0};
      tbl[5] = '{ 32767, 2047, 300,  32767, 1'b1};
      tbl[6] = '{-32768, 2047, 300, -32768, 1'b1};

      rst_n = 1'b0;
      bus.i_Frame_Start = 1'b0; bus.i_Sample_Valid = 1'b0; bus.i_Sample = '0;
      bus.i_Last = 1'b0; bus.i_Mult = '0; bus.i_Mult_Ready = 1'b0;

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk(bus.o_Ready == 1'b1, "rst_ready", bus.o_Ready, 1);
      chk(bus.o_Mix_Out == '0, "rst_mix_out", longint'(bus.o_Mix_Out), 0);
      chk(bus.o_Mix_Valid == 1'b0, "rst_mix_valid", bus.o_Mix_Valid, 0);
      chk(bus.o_Overflow == 1'b0, "rst_ovf", bus.o_Overflow, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven frames of n identical harmonics
      for (int t = 0; t < 7; t++) begin
         pulse_fs();
         acc_cnt = 0;
         for (int h = 0; h < tbl[t].n; h++) begin
            send(tbl[t].s, tbl[t].m, h == tbl[t].n - 1, ok);
            if (ok) acc_cnt++;
         end
         chk(acc_cnt == tbl[t].n, "tbl_accepts", acc_cnt, tbl[t].n);
         wait_mix(v, ovf, got);
         chk(got, "tbl_mix_valid", got, 1);
         chk(v == tbl[t].exp_mix, "tbl_mix", v, tbl[t].exp_mix);
         chk(ovf == tbl[t].exp_ovf, "tbl_ovf", ovf, tbl[t].exp_ovf);
      end

      // Reset in sm_accum: overflow and mix output are non-zero beforehand
      send(1000, 1000, 1'b0, ok);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk(bus.o_Ready == 1'b1, "midrst_ready", bus.o_Ready, 1);
      chk(bus.o_Scale_Start == 1'b0, "midrst_scale", bus.o_Scale_Start, 0);
      chk(bus.o_Mix_Out == '0, "midrst_mix_out", longint'(bus.o_Mix_Out), 0);
      chk(bus.o_Mix_Valid == 1'b0, "midrst_mix_valid", bus.o_Mix_Valid, 0);
      chk(bus.o_Overflow == 1'b0, "midrst_ovf", bus.o_Overflow, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk(bus.o_Ready == 1'b1, "postrst_ready", bus.o_Ready, 1);
      @(posedge clk); #1;

      // Three harmonics: 7996 - 2000 + 0 = 5996 -> 374
      pulse_fs();
      acc_cnt = 0;
      send(8000, 2047, 1'b0, ok);  if (ok) acc_cnt++;
      send(-4000, 1024, 1'b0, ok); if (ok) acc_cnt++;
      send(2000, 0, 1'b1, ok);     if (ok) acc_cnt++;
      chk(acc_cnt == 3, "three_accepts", acc_cnt, 3);
      wait_mix(v, ovf, got);
      chk(got && v == 374, "three_mix", v, 374);
      chk(ovf == 1'b0, "three_ovf", ovf, 0);

      // Abort in sm_mult of the second (last) harmonic
      pulse_fs();
      send(20000, 2047, 1'b0, ok);
      send(20000, 2047, 1'b1, ok);
      bus.i_Frame_Start = 1'b1;
      @(posedge clk); #1;
      bus.i_Frame_Start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk(bus.o_Mix_Valid == 1'b0, "abort_no_mix", bus.o_Mix_Valid, 0);
      end
      @(posedge clk); #1;
      send(16384, 1024, 1'b1, ok);
      wait_mix(v, ovf, got);
      chk(got && v == 512, "abort_next_mix", v, 512);

      // Handshake stall: multiple not ready for 5 cycles
      pulse_fs();
      bus.i_Sample = 16'sd16384; bus.i_Mult = 11'd1024; bus.i_Last = 1'b1;
      bus.i_Sample_Valid = 1'b1; bus.i_Mult_Ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk(bus.o_Scale_Start == 1'b0, "stall_no_start", bus.o_Scale_Start, 0);
         @(posedge clk); #1;
      end
      bus.i_Mult_Ready = 1'b1;
      @(negedge clk);
      chk(bus.o_Scale_Start == 1'b1, "stall_accept", bus.o_Scale_Start, 1);
      @(posedge clk); #1;
      bus.i_Sample_Valid = 1'b0; bus.i_Last = 1'b0;
      @(negedge clk);
      chk(bus.o_Ready == 1'b0, "stall_busy", bus.o_Ready, 0);
      wait_mix(v, ovf, got);
      chk(got && v == 512, "stall_mix", v, 512);

      // Random traffic; phase 1 favours long positive frames to reach clipping
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 2500; i++) begin
            int r;
            bus.i_Frame_Start  = (ph == 0) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 199) == 0);
            bus.i_Sample_Valid = ($urandom_range(0, 3) != 0);
            bus.i_Mult_Ready   = ($urandom_range(0, 3) != 0);
            bus.i_Last         = (ph == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
            if (ph == 1 && $urandom_range(0, 7) != 0)
               bus.i_Sample = SAMPLE_BIT'(32000 + $urandom_range(0, 767));
            else
               bus.i_Sample = SAMPLE_BIT'($urandom);
            r = $urandom_range(0, 9);
            bus.i_Mult = (r == 0) ? '0 : (r == 1) ? 11'd2047 : DIV_BIT'($urandom);
            @(posedge clk); #1;
         end
      end
      bus.i_Frame_Start = 1'b0; bus.i_Sample_Valid = 1'b0;
      bus.i_Last = 1'b0; bus.i_Mult_Ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk(pend.size() == 0, "drain_pending", pend.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
